axi_slave_read: RTL and testbench

AXI4 slave read-channel controller sitting directly downstream of the master read FSM across the interconnect: accepts AR requests, fetches beats from a synchronous single-port word SRAM, and returns them on the R channel. Serves both single-beat uncached reads and the 4-beat INCR cache-line refills the master issues. Out-of-range addresses return DECERR beats without touching memory.

---
 rtl/axi_slave_read.sv | 174 +++++++++++++++++
 tb/tb_axi_slave_read.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_read.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_read
// Description : AXI4 read-channel slave in front of a synchronous word SRAM.
//               Optional WRAP bursts are built when AXI_SLAVE_RD_WRAP_EN is
//               defined; otherwise WRAP is handled as INCR.
// Revision    : 1.0  initial release
// ============================================================================
module axi_slave_read #(
  parameter int          ID_BITS   = 8,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ID_BITS-1:0] ARID,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [ID_BITS-1:0] RID,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               mem_cs,
  output logic [13:0]        mem_addr,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t             state_q, state_d;
  logic [ID_BITS-1:0] id_q, id_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         burst_q, burst_d;
  logic               hit_q, hit_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic               rlast_q, rlast_d;
  logic [1:0]         rresp_q, rresp_d;
  logic               mem_cs_q, mem_cs_d;
  logic [13:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        addr_next;
  logic               unused_arsize;

  assign unused_arsize = ^ARSIZE;

`ifdef AXI_SLAVE_RD_WRAP_EN
  logic [31:0] wrap_mask;
  logic        wrap_len_ok;

  // Wrapping only makes sense for power-of-two beat counts of 2..16.
  assign wrap_len_ok = (len_q != 4'd0) && ((len_q & (len_q + 4'd1)) == 4'd0);
  assign wrap_mask   = {26'd0, len_q, 2'b11};
`endif

  always_comb begin
    addr_next = addr_q + 32'd4;
    if (burst_q == BURST_FIXED) begin
      addr_next = addr_q;
    end
`ifdef AXI_SLAVE_RD_WRAP_EN
    else if (burst_q == 2'b10 && wrap_len_ok) begin
      addr_next = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    hit_d   = hit_q;

    case (state_q)
      IDLE: begin
        if (ARVALID && arready_q) begin
          id_d    = ARID;
          addr_d  = ARADDR;
          len_d   = ARLEN;
          burst_d = ARBURST;
          hit_d   = (ARADDR[31:16] == ADDR_BASE[31:16]);
          cnt_d   = 4'd0;
          state_d = MEM;
        end
      end
      MEM: begin
        state_d = RESP;
      end
      RESP: begin
        if (RREADY) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            addr_d  = addr_next;
            state_d = MEM;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    arready_d  = (state_d == IDLE);
    mem_cs_d   = (state_d == MEM) && hit_d;
    mem_addr_d = (state_d == MEM) ? addr_d[15:2] : mem_addr_q;
    rvalid_d   = (state_d == RESP);
    rlast_d    = rvalid_d && (cnt_d == len_d);
    rresp_d    = (rvalid_d && !hit_d) ? RESP_DECERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= 32'd0;
      len_q      <= 4'd0;
      cnt_q      <= 4'd0;
      burst_q    <= 2'b00;
      hit_q      <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
      mem_cs_q   <= 1'b0;
      mem_addr_q <= 14'd0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      burst_q    <= burst_d;
      hit_q      <= hit_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      mem_cs_q   <= mem_cs_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // SRAM data arrives during RESP and is held by the SRAM while mem_cs is low.
  assign RDATA    = (rvalid_q && hit_q) ? mem_rdata : 32'd0;
  assign ARREADY  = arready_q;
  assign RID      = id_q;
  assign RRESP    = rresp_q;
  assign RLAST    = rlast_q;
  assign RVALID   = rvalid_q;
  assign mem_cs   = mem_cs_q;
  assign mem_addr = mem_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_read.sv
`default_nettype none
// Directed bench for axi_slave_read with a behavioural synchronous SRAM.
module tb_axi_slave_read;

  logic        clk;
  logic        rst;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        mem_cs;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:16383];
  logic [13:0] addr_log [$];
  int total = 0;
  int bad   = 0;

  axi_slave_read #(.ID_BITS(8), .ADDR_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs) begin
      mem_rdata <= mem[mem_addr];
      addr_log.push_back(mem_addr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst,
                         output logic acc);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    for (int k = 0; k < 20 && ARREADY !== 1'b1; k++) tick;
    acc = (ARREADY === 1'b1);
    tick;
    ARVALID = 1'b0;
  endtask

  task automatic wait_rvalid(output logic got);
    for (int k = 0; k < 10 && RVALID !== 1'b1; k++) tick;
    got = (RVALID === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick; tick; tick;
    total++; if (ARREADY !== 1'b0) begin bad++; $display("FAIL rst_arready: got %b want 0", ARREADY); end
    total++; if (RVALID !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", RVALID); end
    total++; if (RLAST !== 1'b0) begin bad++; $display("FAIL rst_rlast: got %b want 0", RLAST); end
    total++; if (mem_cs !== 1'b0) begin bad++; $display("FAIL rst_mem_cs: got %b want 0", mem_cs); end
    total++; if (RID !== 8'h00) begin bad++; $display("FAIL rst_rid: got %h want 00", RID); end
    total++; if (RRESP !== 2'b00) begin bad++; $display("FAIL rst_rresp: got %b want 00", RRESP); end
    total++; if (RDATA !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", RDATA); end
    total++; if (mem_addr !== 14'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    rst = 1'b1;
    tick;
    total++; if (ARREADY !== 1'b1) begin bad++; $display("FAIL rst_release_arready: got %b want 1", ARREADY); end
  endtask

  task automatic test_single;
    logic acc;
    RREADY = 1'b1;
    send_ar(8'h5A, 32'h0000_0010, 4'd0, 2'b01, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_ar: got %b want 1", acc); end
    total++; if (RVALID !== 1'b0 || mem_cs !== 1'b1 || mem_addr !== 14'h4)
      begin bad++; $display("FAIL single_mem: got rvalid %b cs %b addr %h want 0 1 0004", RVALID, mem_cs, mem_addr); end
    tick;
    total++; if (RVALID !== 1'b1) begin bad++; $display("FAIL single_latency: got rvalid %b want 1", RVALID); end
    total++; if (RDATA !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata: got %h want deadbeef", RDATA); end
    total++; if (RRESP !== 2'b00 || RLAST !== 1'b1) begin bad++; $display("FAIL single_resp_last: got %b %b want 00 1", RRESP, RLAST); end
    total++; if (RID !== 8'h5A) begin bad++; $display("FAIL single_rid: got %h want 5a", RID); end
    tick;
    total++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin bad++; $display("FAIL single_done: got rvalid %b arready %b want 0 1", RVALID, ARREADY); end
  endtask

  task automatic test_incr_stall;
    logic acc, got;
    logic [31:0] held;
    addr_log.delete();
    RREADY = 1'b1;
    send_ar(8'h21, 32'h0000_0100, 4'd3, 2'b01, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL incr_ar: got %b want 1", acc); end
    for (int b = 0; b < 4; b++) begin
      wait_rvalid(got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL incr_timeout beat %0d: got %b want 1", b, got); end
      if (b == 1) begin
        RREADY = 1'b0;
        held = RDATA;
        for (int k = 0; k < 3; k++) begin
          tick;
          total++;
          if (RVALID !== 1'b1 || RDATA !== held || RRESP !== 2'b00 || RLAST !== 1'b0)
            begin bad++; $display("FAIL incr_hold cyc %0d: got %b %h %b %b want 1 %h 00 0", k, RVALID, RDATA, RRESP, RLAST, held); end
        end
        RREADY = 1'b1;
      end
      total++; if (RDATA !== 32'hA500_0040 + 32'(b)) begin bad++; $display("FAIL incr_rdata beat %0d: got %h want %h", b, RDATA, 32'hA500_0040 + 32'(b)); end
      total++; if (RLAST !== (b == 3)) begin bad++; $display("FAIL incr_rlast beat %0d: got %b want %b", b, RLAST, (b == 3)); end
      tick;
    end
    total++; if (addr_log.size() != 4) begin bad++; $display("FAIL incr_cs_count: got %0d want 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      total++; if (addr_log[i] !== 14'h40 + 14'(i)) begin bad++; $display("FAIL incr_mem_addr %0d: got %h want %h", i, addr_log[i], 14'h40 + 14'(i)); end
    end
  endtask

  task automatic test_miss;
    logic acc, got;
    addr_log.delete();
    RREADY = 1'b1;
    send_ar(8'h33, 32'h1000_0000, 4'd3, 2'b01, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL miss_ar: got %b want 1", acc); end
    for (int b = 0; b < 4; b++) begin
      wait_rvalid(got);
      total++; if (got !== 1'b1) begin bad++; $display("FAIL miss_timeout beat %0d: got %b want 1", b, got); end
      total++;
      if (RDATA !== 32'h0 || RRESP !== 2'b11 || RLAST !== (b == 3) || RID !== 8'h33)
        begin bad++; $display("FAIL miss_beat %0d: got %h %b %b %h want 0 11 %b 33", b, RDATA, RRESP, RLAST, RID, (b == 3)); end
      tick;
    end
    total++; if (addr_log.size() != 0) begin bad++; $display("FAIL miss_cs: got %0d strobes want 0", addr_log.size()); end
  endtask

  task automatic test_wrap;
    logic acc, got;
    logic [13:0] exp_addr [4];
    logic [31:0] exp_data [4];
`ifdef AXI_SLAVE_RD_WRAP_EN
    exp_addr = '{14'h2, 14'h3, 14'h0, 14'h1};
    exp_data = '{32'hA500_0002, 32'hA500_0003, 32'hA500_0000, 32'hA500_0001};
`else
    exp_addr = '{14'h2, 14'h3, 14'h4, 14'h5};
    exp_data = '{32'hA500_0002, 32'hA500_0003, 32'hDEADBEEF, 32'hA500_0005};
`endif
    addr_log.delete();
    RREADY = 1'b1;
    send_ar(8'h77, 32'h0000_0008, 4'd3, 2'b10, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL wrap_ar: got %b want 1", acc); end
    for (int b = 0; b < 4; b++) begin
      wait_rvalid(got);
      total++; if (got !== 1'b1 || RDATA !== exp_data[b] || RLAST !== (b == 3))
        begin bad++; $display("FAIL wrap_beat %0d: got v%b %h l%b want v1 %h l%b", b, RVALID, RDATA, RLAST, exp_data[b], (b == 3)); end
      tick;
    end
    total++; if (addr_log.size() != 4) begin bad++; $display("FAIL wrap_cs_count: got %0d want 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      total++; if (addr_log[i] !== exp_addr[i]) begin bad++; $display("FAIL wrap_mem_addr %0d: got %h want %h", i, addr_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic acc, got;
    RREADY = 1'b1;
    send_ar(8'h66, 32'h0000_0200, 4'd3, 2'b01, acc);
    wait_rvalid(got);
    tick;
    wait_rvalid(got);
    total++; if (got !== 1'b1 || RDATA !== 32'hA500_0081) begin bad++; $display("FAIL rmid_beat2: got v%b %h want v1 a5000081", got, RDATA); end
    rst = 1'b0;
    #1;
    total++; if (RVALID !== 1'b0 || RLAST !== 1'b0 || mem_cs !== 1'b0 || ARREADY !== 1'b0 || RID !== 8'h00)
      begin bad++; $display("FAIL rmid_clear: got %b %b %b %b %h want 0 0 0 0 00", RVALID, RLAST, mem_cs, ARREADY, RID); end
    tick;
    rst = 1'b1;
    tick;
    total++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin bad++; $display("FAIL rmid_release: got arready %b rvalid %b want 1 0", ARREADY, RVALID); end
    send_ar(8'h67, 32'h0000_0014, 4'd0, 2'b01, acc);
    wait_rvalid(got);
    total++; if (got !== 1'b1 || RDATA !== 32'hA500_0005 || RID !== 8'h67 || RLAST !== 1'b1)
      begin bad++; $display("FAIL rmid_next: got v%b %h %h l%b want v1 a5000005 67 l1", got, RDATA, RID, RLAST); end
    tick;
  endtask

  task automatic test_back_to_back;
    int early = 0;
    int n = 0;
    RREADY = 1'b1;
    ARID = 8'h41; ARADDR = 32'h0000_0020; ARLEN = 4'd1; ARBURST = 2'b01; ARVALID = 1'b1;
    tick;
    ARID = 8'h42; ARADDR = 32'h0000_0030; ARLEN = 4'd0;
    while (!(RVALID === 1'b1 && RLAST === 1'b1) && n < 20) begin
      if (ARREADY !== 1'b0) early++;
      tick;
      n++;
    end
    if (ARREADY !== 1'b0) early++;
    total++; if (early != 0) begin bad++; $display("FAIL b2b_early_ready: got %0d cycles want 0", early); end
    total++; if (n != 3) begin bad++; $display("FAIL b2b_burst_cycles: got %0d want 3", n); end
    tick;
    total++; if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_last: got %b %b want 1 0", ARREADY, RVALID); end
    tick;
    ARVALID = 1'b0;
    total++; if (mem_cs !== 1'b1 || mem_addr !== 14'hC || ARREADY !== 1'b0)
      begin bad++; $display("FAIL b2b_accept: got cs %b addr %h rdy %b want 1 000c 0", mem_cs, mem_addr, ARREADY); end
    tick;
    total++; if (RVALID !== 1'b1 || RID !== 8'h42 || RDATA !== 32'hA500_000C || RLAST !== 1'b1)
      begin bad++; $display("FAIL b2b_second: got v%b %h %h l%b want v1 42 a500000c l1", RVALID, RID, RDATA, RLAST); end
    tick;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[4]    = 32'hDEADBEEF;
    mem_rdata = 32'h0;
    ARID = 8'h0; ARADDR = 32'h0; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b0; RREADY = 1'b1; rst = 1'b0;
    test_reset;
    test_single;
    test_incr_stall;
    test_miss;
    test_wrap;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
